// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the run sequencer and the 8-bit CPU datapath.
//   HALT_OP      - opcode that stops execution
//   INSTR_BYTES  - bytes per instruction (opcode, arg1, arg2, dest)
//   OP_*         - datapath opcode constants
//   seq_state_t  - sequencer FSM states
//   run_mode_t   - execution mode latched when a run starts
package cpu_pkg;

    localparam logic [7:0] HALT_OP     = 8'h32;
    localparam int         INSTR_BYTES = 4;

    localparam logic [7:0] OP_ADD = 8'h00;
    localparam logic [7:0] OP_SUB = 8'h01;
    localparam logic [7:0] OP_MUL = 8'h02;
    localparam logic [7:0] OP_DIV = 8'h03;
    localparam logic [7:0] OP_MOD = 8'h04;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_F0,
        ST_F1,
        ST_F2,
        ST_F3,
        ST_F4,
        ST_EXEC,
        ST_WAIT,
        ST_HALTED
    } seq_state_t;

    typedef enum logic [1:0] {
        MODE_STEP,
        MODE_RUN,
        MODE_FAST
    } run_mode_t;

endpackage

// File: rtl/pulse_edge.sv
// pulse_edge: registered rising-edge detector.
//   clk  - clock
//   rst  - asynchronous active-low reset
//   d    - level input
//   rise - high for the cycle in which d is 1 and its registered copy is 0
module pulse_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_reg <= 1'b0;
        end else begin
            d_reg <= d;
        end
    end

    assign rise = d & ~d_reg;

endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: shares the program ROM between the front-panel editor and
// instruction fetch, fetches 4-byte instructions and strobes them into the
// datapath in STEP / RUN / FAST modes, stopping on HALT_OP.
//   clk, rst                  - clock, asynchronous active-low reset
//   edit, unit, code, send    - editor ownership, write address/data/request
//   program_sel               - ROM bank select
//   RUN, NEXT, SPEEDRUN       - panel buttons (rising edge acts)
//   rom_addr/bank/we/wdata    - ROM port;  rom_rdata - synchronous read data
//   opcode, arg1, arg2, dest  - latched instruction fields
//   exec                      - one-cycle execute strobe
//   pc_load, pc_wdata         - datapath write of the counter (EXEC cycle only)
//   pc, busy, halted          - counter and status
module run_sequencer #(
    parameter int         TICK_DIV = 4,
    parameter logic [7:0] HALT_OP  = cpu_pkg::HALT_OP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       edit,
    input  logic [7:0] unit,
    input  logic [7:0] code,
    input  logic       send,
    input  logic [1:0] program_sel,
    input  logic       RUN,
    input  logic       NEXT,
    input  logic       SPEEDRUN,
    output logic [7:0] rom_addr,
    output logic [1:0] rom_bank,
    output logic       rom_we,
    output logic [7:0] rom_wdata,
    input  logic [7:0] rom_rdata,
    output logic [7:0] opcode,
    output logic [7:0] arg1,
    output logic [7:0] arg2,
    output logic [7:0] dest,
    output logic       exec,
    input  logic       pc_load,
    input  logic [7:0] pc_wdata,
    output logic [7:0] pc,
    output logic       busy,
    output logic       halted
);

    import cpu_pkg::*;

    localparam int B_NEXT  = 0;
    localparam int B_RUN   = 1;
    localparam int B_SPEED = 2;
    localparam int B_SEND  = 3;

    localparam int             CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  WAIT_LAST = CW'(TICK_DIV - 1);

    seq_state_t    state_reg;
    run_mode_t     mode_reg;
    logic          stop_reg;
    logic [7:0]    pc_reg;
    logic [7:0]    opcode_reg, arg1_reg, arg2_reg, dest_reg;
    logic [7:0]    addr_reg, wdata_reg;
    logic [1:0]    bank_reg;
    logic          we_reg;
    logic [CW-1:0] wait_reg;

    logic [3:0] btn, btn_rise;
    logic       busy_int;
    logic [7:0] pc_exec;

    assign btn = {send, SPEEDRUN, RUN, NEXT};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_edge
            pulse_edge u_edge (
                .clk  (clk),
                .rst  (rst),
                .d    (btn[gi]),
                .rise (btn_rise[gi])
            );
        end
    endgenerate

    assign busy_int = (state_reg != ST_IDLE) && (state_reg != ST_HALTED);
    assign pc_exec  = pc_load ? pc_wdata : pc_reg + 8'(INSTR_BYTES);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            mode_reg   <= MODE_STEP;
            stop_reg   <= 1'b0;
            pc_reg     <= 8'd0;
            opcode_reg <= 8'd0;
            arg1_reg   <= 8'd0;
            arg2_reg   <= 8'd0;
            dest_reg   <= 8'd0;
            addr_reg   <= 8'd0;
            bank_reg   <= 2'd0;
            wdata_reg  <= 8'd0;
            we_reg     <= 1'b0;
            wait_reg   <= '0;
        end else begin
            we_reg <= 1'b0;
            if (edit) begin
                // Editor owns the ROM: abandon any fetch and mirror the editor
                // onto the ROM port every cycle; write only on a send edge.
                state_reg <= ST_IDLE;
                mode_reg  <= MODE_STEP;
                stop_reg  <= 1'b0;
                pc_reg    <= 8'd0;
                wait_reg  <= '0;
                addr_reg  <= unit;
                bank_reg  <= program_sel;
                wdata_reg <= code;
                we_reg    <= btn_rise[B_SEND];
            end else begin
                // NEXT while running requests a stop at the next EXEC;
                // the EXEC branch below overrides this when it consumes it.
                if (btn_rise[B_NEXT] && busy_int) begin
                    stop_reg <= 1'b1;
                end
                case (state_reg)
                    ST_IDLE: begin
                        if (btn_rise[B_SPEED] || btn_rise[B_RUN] || btn_rise[B_NEXT]) begin
                            mode_reg  <= btn_rise[B_SPEED] ? MODE_FAST :
                                         btn_rise[B_RUN]   ? MODE_RUN  : MODE_STEP;
                            bank_reg  <= program_sel;
                            addr_reg  <= pc_reg;
                            state_reg <= ST_F0;
                        end
                    end
                    // rom_addr is set one state ahead; read data arrives one
                    // cycle after its address, so each byte is captured a
                    // state later than its address was presented.
                    ST_F0: begin
                        addr_reg  <= pc_reg + 8'd1;
                        state_reg <= ST_F1;
                    end
                    ST_F1: begin
                        opcode_reg <= rom_rdata;
                        addr_reg   <= pc_reg + 8'd2;
                        state_reg  <= ST_F2;
                    end
                    ST_F2: begin
                        arg1_reg  <= rom_rdata;
                        addr_reg  <= pc_reg + 8'd3;
                        state_reg <= ST_F3;
                    end
                    ST_F3: begin
                        arg2_reg  <= rom_rdata;
                        state_reg <= ST_F4;
                    end
                    ST_F4: begin
                        dest_reg  <= rom_rdata;
                        state_reg <= (opcode_reg == HALT_OP) ? ST_HALTED : ST_EXEC;
                    end
                    ST_EXEC: begin
                        pc_reg <= pc_exec;
                        if (stop_reg || mode_reg == MODE_STEP) begin
                            stop_reg  <= 1'b0;
                            state_reg <= ST_IDLE;
                        end else if (mode_reg == MODE_FAST) begin
                            addr_reg  <= pc_exec;
                            state_reg <= ST_F0;
                        end else begin
                            wait_reg  <= '0;
                            state_reg <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (wait_reg == WAIT_LAST) begin
                            addr_reg  <= pc_reg;
                            state_reg <= ST_F0;
                        end else begin
                            wait_reg <= wait_reg + 1'b1;
                        end
                    end
                    ST_HALTED: begin
                        state_reg <= ST_HALTED;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign rom_addr  = addr_reg;
    assign rom_bank  = bank_reg;
    assign rom_we    = we_reg;
    assign rom_wdata = wdata_reg;
    assign opcode    = opcode_reg;
    assign arg1      = arg1_reg;
    assign arg2      = arg2_reg;
    assign dest      = dest_reg;
    assign pc        = pc_reg;
    assign exec      = (state_reg == ST_EXEC);
    assign busy      = busy_int;
    assign halted    = (state_reg == ST_HALTED);

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed bench for run_sequencer with a behavioural
// 4-bank synchronous ROM.
module tb_run_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       edit;
    logic [7:0] unit, code;
    logic       send;
    logic [1:0] program_sel;
    logic       RUN, NEXT, SPEEDRUN;
    logic [7:0] rom_addr;
    logic [1:0] rom_bank;
    logic       rom_we;
    logic [7:0] rom_wdata;
    logic [7:0] rom_rdata;
    logic [7:0] opcode, arg1, arg2, dest;
    logic       exec;
    logic       pc_load;
    logic [7:0] pc_wdata;
    logic [7:0] pc;
    logic       busy, halted;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exec_cnt = 0;
    int we_cnt   = 0;

    logic [7:0] rom_mem [4][256];

    typedef struct {
        logic       load;
        logic [7:0] wdata;
        logic [7:0] op, a1, a2, ds;
        logic [7:0] pc_after;
    } step_vec_t;

    step_vec_t steps [5];

    run_sequencer #(.TICK_DIV(4), .HALT_OP(8'h32)) dut (
        .clk         (clk),
        .rst         (rst),
        .edit        (edit),
        .unit        (unit),
        .code        (code),
        .send        (send),
        .program_sel (program_sel),
        .RUN         (RUN),
        .NEXT        (NEXT),
        .SPEEDRUN    (SPEEDRUN),
        .rom_addr    (rom_addr),
        .rom_bank    (rom_bank),
        .rom_we      (rom_we),
        .rom_wdata   (rom_wdata),
        .rom_rdata   (rom_rdata),
        .opcode      (opcode),
        .arg1        (arg1),
        .arg2        (arg2),
        .dest        (dest),
        .exec        (exec),
        .pc_load     (pc_load),
        .pc_wdata    (pc_wdata),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rom_we) rom_mem[rom_bank][rom_addr] <= rom_wdata;
        rom_rdata <= rom_mem[rom_bank][rom_addr];
    end

    always @(negedge clk) begin
        if (exec)   exec_cnt <= exec_cnt + 1;
        if (rom_we) we_cnt   <= we_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic write_byte(input logic [1:0] b, input logic [7:0] a, input logic [7:0] d);
        edit = 1'b1; program_sel = b; unit = a; code = d; send = 1'b1;
        tick();
        chk("wr_we", {31'd0, rom_we}, 32'd1);
        chk("wr_addr", {24'd0, rom_addr}, {24'd0, a});
        chk("wr_data", {24'd0, rom_wdata}, {24'd0, d});
        chk("wr_bank", {30'd0, rom_bank}, {30'd0, b});
        send = 1'b0;
        tick();
        chk("wr_we_drop", {31'd0, rom_we}, 32'd0);
    endtask

    task automatic write_instr(input logic [1:0] b, input logic [7:0] a,
                               input logic [7:0] op, input logic [7:0] x1,
                               input logic [7:0] x2, input logic [7:0] ds);
        write_byte(b, a, op);
        write_byte(b, a + 8'd1, x1);
        write_byte(b, a + 8'd2, x2);
        write_byte(b, a + 8'd3, ds);
    endtask

    task automatic wait_exec(input string name);
        int n = 0;
        while (exec !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk(name, {31'd0, exec}, 32'd1);
    endtask

    task automatic wait_halt(input string name);
        int n = 0;
        while (halted !== 1'b1 && n < 120) begin
            tick();
            n++;
        end
        chk(name, {31'd0, halted}, 32'd1);
    endtask

    task automatic edit_pulse(input logic [1:0] b);
        program_sel = b;
        edit = 1'b1;
        tick();
        edit = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, w0, prev;

        steps[0] = '{1'b1, 8'd252, 8'h01, 8'h11, 8'h22, 8'h33, 8'd252};
        steps[1] = '{1'b0, 8'd0,   8'h04, 8'hAA, 8'hBB, 8'hCC, 8'd0};
        steps[2] = '{1'b0, 8'd0,   8'h01, 8'h11, 8'h22, 8'h33, 8'd4};
        steps[3] = '{1'b1, 8'd20,  8'h03, 8'h44, 8'h55, 8'h66, 8'd20};
        steps[4] = '{1'b0, 8'd0,   8'h02, 8'h05, 8'h06, 8'h07, 8'd24};

        rst = 1'b0; edit = 1'b0; unit = 8'd0; code = 8'd0; send = 1'b0;
        program_sel = 2'd0; RUN = 1'b0; NEXT = 1'b0; SPEEDRUN = 1'b0;
        pc_load = 1'b0; pc_wdata = 8'd0;

        // Reset values
        repeat (3) tick();
        chk("rst_pc", {24'd0, pc}, 32'd0);
        chk("rst_opcode", {24'd0, opcode}, 32'd0);
        chk("rst_rom_addr", {24'd0, rom_addr}, 32'd0);
        chk("rst_rom_bank", {30'd0, rom_bank}, 32'd0);
        chk("rst_rom_wdata", {24'd0, rom_wdata}, 32'd0);
        chk("rst_rom_we", {31'd0, rom_we}, 32'd0);
        chk("rst_exec", {31'd0, exec}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        #2 rst = 1'b1;
        tick();

        // Program all banks in one editor session
        write_instr(2'd0, 8'd0, 8'h00, 8'd7, 8'd7, 8'd0);
        write_instr(2'd0, 8'd4, 8'h32, 8'd0, 8'd0, 8'd0);
        for (int k = 0; k < 8; k++)
            write_instr(2'd1, 8'(k * 4), 8'h00, 8'(k), 8'(k + 1), 8'(k + 2));
        write_instr(2'd1, 8'd32, 8'h32, 8'd0, 8'd0, 8'd0);
        write_instr(2'd2, 8'd0, 8'h00, 8'd1, 8'd2, 8'd3);
        write_instr(2'd2, 8'd20, 8'h32, 8'd0, 8'd0, 8'd0);
        write_instr(2'd3, 8'd0, 8'h01, 8'h11, 8'h22, 8'h33);
        write_instr(2'd3, 8'd4, 8'h03, 8'h44, 8'h55, 8'h66);
        write_instr(2'd3, 8'd20, 8'h02, 8'h05, 8'h06, 8'h07);
        write_instr(2'd3, 8'd252, 8'h04, 8'hAA, 8'hBB, 8'hCC);
        program_sel = 2'd0;
        edit = 1'b0;
        tick();

        // Single step ADD 7,7,0 then HALT
        e0 = exec_cnt;
        NEXT = 1'b1; tick(); NEXT = 1'b0;
        chk("step_busy", {31'd0, busy}, 32'd1);
        wait_exec("step_exec_seen");
        chk("step_opcode", {24'd0, opcode}, 32'h00);
        chk("step_arg1", {24'd0, arg1}, 32'd7);
        chk("step_arg2", {24'd0, arg2}, 32'd7);
        chk("step_dest", {24'd0, dest}, 32'd0);
        tick();
        chk("step_pc", {24'd0, pc}, 32'd4);
        chk("step_idle", {31'd0, busy}, 32'd0);
        chk("step_one_exec", exec_cnt - e0, 32'd1);
        NEXT = 1'b1; tick(); NEXT = 1'b0;
        wait_halt("halt_seen");
        repeat (5) tick();
        chk("halt_hold", {31'd0, halted}, 32'd1);
        chk("halt_pc", {24'd0, pc}, 32'd4);
        chk("halt_no_exec", exec_cnt - e0, 32'd1);
        chk("halt_not_busy", {31'd0, busy}, 32'd0);

        // SPEEDRUN: 8 instructions, 6 cycles apart
        edit_pulse(2'd1);
        e0 = exec_cnt; prev = 0;
        SPEEDRUN = 1'b1; tick(); SPEEDRUN = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_exec("fast_exec_seen");
            if (i > 0) chk("fast_gap", cyc - prev, 32'd6);
            chk("fast_arg1", {24'd0, arg1}, i);
            prev = cyc;
            tick();
        end
        wait_halt("fast_halt");
        chk("fast_pc", {24'd0, pc}, 32'd32);
        chk("fast_count", exec_cnt - e0, 32'd8);
        chk("fast_bank", {30'd0, rom_bank}, 32'd1);

        // RUN: 8 instructions, 10 cycles apart with TICK_DIV=4
        edit_pulse(2'd1);
        e0 = exec_cnt; prev = 0;
        RUN = 1'b1; tick(); RUN = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_exec("run_exec_seen");
            if (i > 0) chk("run_gap", cyc - prev, 32'd10);
            prev = cyc;
            tick();
        end
        wait_halt("run_halt");
        chk("run_pc", {24'd0, pc}, 32'd32);
        chk("run_count", exec_cnt - e0, 32'd8);

        // pc_load during EXEC redirects the next fetch
        edit_pulse(2'd2);
        e0 = exec_cnt;
        SPEEDRUN = 1'b1; tick(); SPEEDRUN = 1'b0;
        wait_exec("load_exec_seen");
        pc_load = 1'b1; pc_wdata = 8'd20;
        tick();
        pc_load = 1'b0; pc_wdata = 8'd0;
        chk("load_f0_addr", {24'd0, rom_addr}, 32'd20);
        chk("load_pc", {24'd0, pc}, 32'd20);
        wait_halt("load_halt");
        chk("load_halt_pc", {24'd0, pc}, 32'd20);
        chk("load_count", exec_cnt - e0, 32'd1);

        // Table of single steps in bank 3, including the 252 -> 0 wrap
        edit_pulse(2'd3);
        for (int i = 0; i < 5; i++) begin
            NEXT = 1'b1; tick(); NEXT = 1'b0;
            wait_exec("tab_exec_seen");
            chk("tab_opcode", {24'd0, opcode}, {24'd0, steps[i].op});
            chk("tab_arg1", {24'd0, arg1}, {24'd0, steps[i].a1});
            chk("tab_arg2", {24'd0, arg2}, {24'd0, steps[i].a2});
            chk("tab_dest", {24'd0, dest}, {24'd0, steps[i].ds});
            chk("tab_bank", {30'd0, rom_bank}, 32'd3);
            pc_load = steps[i].load; pc_wdata = steps[i].wdata;
            tick();
            pc_load = 1'b0; pc_wdata = 8'd0;
            chk("tab_pc", {24'd0, pc}, {24'd0, steps[i].pc_after});
            chk("tab_idle", {31'd0, busy}, 32'd0);
        end

        // NEXT during F2 of a FAST run stops after the current instruction
        edit_pulse(2'd1);
        e0 = exec_cnt;
        SPEEDRUN = 1'b1; tick(); SPEEDRUN = 1'b0;
        tick();
        tick();
        chk("stop_f2_addr", {24'd0, rom_addr}, 32'd2);
        NEXT = 1'b1; tick(); NEXT = 1'b0;
        wait_exec("stop_exec_seen");
        tick();
        chk("stop_idle", {31'd0, busy}, 32'd0);
        chk("stop_pc", {24'd0, pc}, 32'd4);
        repeat (15) tick();
        chk("stop_count", exec_cnt - e0, 32'd1);
        chk("stop_still_idle", {31'd0, busy}, 32'd0);

        // edit raised during F3 abandons the fetch
        e0 = exec_cnt;
        NEXT = 1'b1; tick(); NEXT = 1'b0;
        tick(); tick(); tick();
        chk("abort_f3_addr", {24'd0, rom_addr}, 32'd7);
        edit = 1'b1;
        tick();
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_pc", {24'd0, pc}, 32'd0);
        chk("abort_exec", {31'd0, exec}, 32'd0);
        repeat (8) tick();
        chk("abort_count", exec_cnt - e0, 32'd0);

        // Editor passthrough and a single write per send edge
        unit = 8'd9; code = 8'h05; program_sel = 2'd0;
        tick();
        chk("ed_pass_addr", {24'd0, rom_addr}, 32'd9);
        chk("ed_pass_we", {31'd0, rom_we}, 32'd0);
        w0 = we_cnt;
        send = 1'b1;
        tick();
        chk("ed_we", {31'd0, rom_we}, 32'd1);
        chk("ed_addr", {24'd0, rom_addr}, 32'd9);
        chk("ed_wdata", {24'd0, rom_wdata}, 32'h05);
        repeat (3) tick();
        send = 1'b0;
        repeat (2) tick();
        chk("ed_single_we", we_cnt - w0, 32'd1);
        edit = 1'b0;
        tick();
        chk("ed_fall_idle", {31'd0, busy}, 32'd0);
        send = 1'b1;
        tick();
        chk("ed_send_ignored", {31'd0, rom_we}, 32'd0);
        send = 1'b0;
        tick();

        // Asynchronous reset in the middle of EXEC
        program_sel = 2'd1;
        SPEEDRUN = 1'b1; tick(); SPEEDRUN = 1'b0;
        wait_exec("rst_run_exec1");
        tick();
        wait_exec("rst_run_exec2");
        chk("rst_run_pc_before", {24'd0, pc}, 32'd4);
        e0 = exec_cnt;
        rst = 1'b0;
        #1;
        chk("arst_exec", {31'd0, exec}, 32'd0);
        chk("arst_pc", {24'd0, pc}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_opcode", {24'd0, opcode}, 32'd0);
        chk("arst_rom_addr", {24'd0, rom_addr}, 32'd0);
        #2 rst = 1'b1;
        repeat (12) tick();
        chk("arst_stay_idle", {31'd0, busy}, 32'd0);
        chk("arst_no_exec", exec_cnt - e0, 32'd0);
        chk("arst_pc_after", {24'd0, pc}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Control sequencer in front of the 8-bit CPU datapath and its program ROM. It shares the single ROM port between the front-panel program editor and instruction fetch. It fetches each 4-byte instruction (opcode, arg1, arg2, dest) and presents it to the datapath with a one-cycle execute strobe. It implements the RUN / NEXT / SPEEDRUN execution modes and stops on HALT.

## Interface
- `TICK_DIV`, default 4: idle cycles between instructions in RUN mode (≥1).
- `HALT_OP`, default 8'h32: opcode that stops execution.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset. Asynchronous, active-low.
- `edit` in 1: level. 1 = editor owns the ROM; execution is inhibited.
- `unit` in 8: editor write address.
- `code` in 8: editor write data.
- `send` in 1: editor write request; acted on at its rising edge.
- `program` in 2: ROM bank select.
- `RUN`, `NEXT`, `SPEEDRUN` in 1 each: panel buttons; acted on at their rising edges.
- `rom_addr` out 8 / `rom_bank` out 2: ROM address.
- `rom_we` out 1 / `rom_wdata` out 8: ROM write port.
- `rom_rdata` in 8: ROM read data, valid one cycle after the address (synchronous ROM).
- `opcode`, `arg1`, `arg2`, `dest` out 8 each: latched instruction fields.
- `exec` out 1: one-cycle execute strobe to the datapath.
- `pc_load` in 1 / `pc_wdata` in 8: datapath write of COUNTER. Sampled only in the EXEC cycle.
- `pc` out 8: program counter, also the COUNTER monitor.
- `busy` out 1: state is not IDLE or HALTED.
- `halted` out 1: state is HALTED.

## Operation
- Button edges are computed as `btn & ~btn_q`, with `btn_q` registered.
- States: IDLE, F0, F1, F2, F3, F4, EXEC, WAIT, HALTED.
- Run mode is one of STEP, RUN or FAST. It is latched when leaving IDLE, with priority SPEEDRUN > RUN > NEXT when edges coincide.
- IDLE: on a qualifying edge with edit=0, go to F0. `rom_bank` is latched from `program` at the same time.
- F0: rom_addr=pc.
- F1: rom_addr=pc+1; capture opcode.
- F2: rom_addr=pc+2; capture arg1.
- F3: rom_addr=pc+3; capture arg2.
- F4: capture dest. If opcode==HALT_OP, go to HALTED; otherwise go to EXEC.
- All address arithmetic is mod 256.
- EXEC: exec=1. pc is updated to `pc_load ? pc_wdata : pc+4` (wraps 252→0). The next state depends on the run mode:
  - STEP → IDLE.
  - FAST → F0.
  - RUN → WAIT.
- WAIT: counts TICK_DIV cycles, then goes to F0.
- A NEXT edge while busy sets a stop flag. At the next EXEC the next state is IDLE regardless of mode, and the flag clears.
- RUN and SPEEDRUN edges while busy are ignored.
- HALTED is held; pc stays at the HALT address. It is exited only by reset or edit=1.
- edit=1 in any state:
  - Next state is IDLE; any in-flight fetch is abandoned and exec is never asserted.
  - pc is cleared to 0, halted and the stop flag clear, and the run mode resets.
- Editor writes:
  - A `send` rising edge with edit=1 gives rom_we=1 for exactly one cycle, with rom_addr=unit, rom_wdata=code, rom_bank=program.
  - `send` with edit=0 is ignored.
  - When edit=1, rom_addr, rom_bank and rom_wdata carry the editor values, whether or not a write is in progress.
- Falling edge of edit: no action. Execution needs a fresh button edge.

## Timing
- Reset values:
  - pc=0, opcode/arg1/arg2/dest=0, rom_addr=0, rom_bank=0, rom_wdata=0.
  - rom_we=0, exec=0, busy=0, halted=0.
  - State IDLE, run mode STEP, edge registers 0.
- Reset mid-fetch or mid-EXEC: all outputs return to their reset values immediately. No partial exec pulse.
- Instruction latency:
  - Entering F0 to the exec pulse: 5 cycles.
  - FAST mode: one instruction every 6 cycles.
  - RUN mode: one instruction every 6+TICK_DIV cycles.
- Button edge to F0: 1 cycle after the edge is seen.
- HALT detection: halted rises 5 cycles after F0, with no exec pulse.
- pc changes on the clock edge ending EXEC and is stable in all other states.

## Structure
- Shared package `cpu_pkg` holds:
  - `HALT_OP`.
  - The instruction width constant `INSTR_BYTES=4`.
  - The state enum `seq_state_t` and the run-mode enum `run_mode_t`.
  - The opcode constants (ADD..MOD), shared with the datapath.
- Sub-module `pulse_edge` provides the registered rising-edge detector. It is instantiated 4× (RUN, NEXT, SPEEDRUN, send).

## Test plan
- Reset, then write ADD 7,7,0 at 0..3 and HALT at 4..7 with edit=1, then drop edit and pulse NEXT.
  - Exactly one exec, with opcode=0, arg1=7, dest=0.
  - pc=4, then IDLE.
  - A second NEXT → halted=1, pc=4, no exec.
- The same program with SPEEDRUN and an 8-instruction body.
  - exec pulses are exactly 6 cycles apart, then halted.
  - RUN with TICK_DIV=4 gives pulses 10 apart.
- pc_load=1, pc_wdata=8'd20 during EXEC → next F0 rom_addr=20.
- Instruction at 252 without a load → pc wraps to 0.
- SPEEDRUN run, NEXT edge mid-F2 → the current instruction completes (exec=1), then IDLE, busy=0.
- edit raised in F3 → no exec, pc=0, IDLE next cycle.
  - send with unit=9, code=8'h05 → a single rom_we cycle with rom_addr=9, rom_wdata=5.
- Assert rst low mid-EXEC of a FAST run → exec=0, pc=0 and busy=0 immediately (asynchronous). After release the sequencer stays IDLE until a new button edge.
